// File: rtl/slice_log_pkg.sv
// slice_log_pkg: shared types and constants for the slice log capture block.
// Holds the capture FSM state encoding, the rd_data field layout and the
// saturation limit of the drop counter.
package slice_log_pkg;

  // Capture controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int SLOT_WIDTH = 4;
  localparam int DROP_WIDTH = 8;
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = 8'd255;

  // rd_data layout, LSB first: value, timestamp, slot, ovf1, ovf2
  localparam int OFF_VALUE = 0;

  function automatic int off_ts(input int dw);
    return dw;
  endfunction

  function automatic int off_slot(input int dw, input int tw);
    return dw + tw;
  endfunction

  function automatic int off_ovf1(input int dw, input int tw);
    return dw + tw + SLOT_WIDTH;
  endfunction

  function automatic int off_ovf2(input int dw, input int tw);
    return dw + tw + SLOT_WIDTH + 1;
  endfunction

  function automatic int word_width(input int dw, input int tw);
    return dw + tw + SLOT_WIDTH + 2;
  endfunction

endpackage

// File: rtl/slice_log_fifo.sv
// slice_log_fifo: synchronous FIFO with a registered output word.
// Pointers carry one extra MSB to tell full from empty. The head word is
// pre-loaded into rd_data_o, so a write into an empty FIFO appears one cycle
// later (no fall-through). A write while full is accepted only if a read
// frees a slot in the same cycle; otherwise it is reported on wr_drop_o.
module slice_log_fifo #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     wr_drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             full_s, empty_s, rd_fire_s, wr_fire_s;

  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign rd_fire_s = rd_valid_q && rd_ready_i;
  assign wr_fire_s = wr_en_i && !flush_i && (!full_s || rd_fire_s);

  // Next pointers, occupancy and the head word to present after this edge
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_fire_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
    level_d    = wr_ptr_d - rd_ptr_d;
    rd_valid_d = (level_d != '0);
    // The incoming word becomes the head only when the FIFO drains to it
    if (level_d == '0) begin
      rd_data_d = rd_data_q;
    end else if (wr_fire_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      rd_data_d = wr_data_i;
    end else begin
      rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // Storage array; contents are unreachable after reset since pointers clear
  always_ff @(posedge clk_i) begin
    if (wr_fire_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointer, level and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign full_o     = full_s;
  assign empty_o    = empty_s;
  assign level_o    = level_q;
  assign wr_drop_o  = wr_en_i && !wr_fire_s;

endmodule

// File: rtl/slice_log_capture.sv
// slice_log_capture: capture buffer behind a filter slice.
// Delays the slice log trigger by LOG_LATENCY cycles, tags each captured value
// with slot, overflow flags and frame timestamp, and queues it for the host.
// Optional feature macro: SLICE_LOG_TIMESTAMP_EN builds the frame timestamp
// counter; without it the timestamp field of rd_data is constant zero.
module slice_log_capture
  import slice_log_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int DEPTH       = 16,
  parameter int TS_WIDTH    = 16,
  parameter int LOG_LATENCY = 1
) (
  input  logic                                            clock_200,
  input  logic                                            reset_n,
  input  logic                                            arm,
  input  logic                                            stop,
  input  logic                                            one_shot,
  input  logic                                            frame_start,
  input  logic                                            log_trigger,
  input  logic [SLOT_WIDTH-1:0]                           log_slot,
  input  logic signed [DATA_WIDTH-1:0]                    log_value_in,
  input  logic                                            overflow_stage_1,
  input  logic                                            overflow_stage_2,
  output logic                                            rd_valid,
  input  logic                                            rd_ready,
  output logic [2+SLOT_WIDTH+TS_WIDTH+DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]                          fill_level,
  output logic [DROP_WIDTH-1:0]                           dropped,
  output logic                                            busy
);

  localparam int AW         = $clog2(DEPTH);
  localparam int WORD_W     = word_width(DATA_WIDTH, TS_WIDTH);
  localparam int OFF_TS_L   = off_ts(DATA_WIDTH);
  localparam int OFF_SLOT_L = off_slot(DATA_WIDTH, TS_WIDTH);
  localparam int OFF_OVF1_L = off_ovf1(DATA_WIDTH, TS_WIDTH);
  localparam int OFF_OVF2_L = off_ovf2(DATA_WIDTH, TS_WIDTH);
  localparam logic [AW:0] LVL_LAST = (AW+1)'(DEPTH - 1);

  state_e                                   state_q, state_d;
  logic [1:0]                               rst_sync_q;
  logic                                     run_s;
  logic [LOG_LATENCY-1:0]                   trig_dly_q;
  logic [LOG_LATENCY-1:0][SLOT_WIDTH-1:0]   slot_dly_q;
  logic                                     one_shot_q;
  logic [DROP_WIDTH-1:0]                    dropped_q, dropped_d;
  logic                                     busy_q;
  logic [TS_WIDTH-1:0]                      ts_s;
  logic [WORD_W-1:0]                        wr_word_s;
  logic wr_req_s, wr_drop_s, rd_fire_s, fifo_full_s, fifo_empty_s;
  logic flush_s, arm_go_s, cap_done_s;

  // Reset release is synchronised before the FSM may leave IDLE
  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign run_s = rst_sync_q[1];

  // Trigger delay line; a trigger is tagged only if it was issued in CAPTURE
  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      trig_dly_q <= '0;
      slot_dly_q <= '0;
    end else begin
      trig_dly_q[0] <= log_trigger && (state_q == CAPTURE);
      slot_dly_q[0] <= log_slot;
      for (int i = 1; i < LOG_LATENCY; i++) begin
        trig_dly_q[i] <= trig_dly_q[i-1];
        slot_dly_q[i] <= slot_dly_q[i-1];
      end
    end
  end

  // In-flight captures complete after stop, but not past a finished one-shot
  assign wr_req_s   = trig_dly_q[LOG_LATENCY-1] && (state_q != DONE);
  assign rd_fire_s  = rd_valid && rd_ready;
  assign arm_go_s   = run_s && arm && !stop && ((state_q == IDLE) || (state_q == DONE));
  assign flush_s    = arm_go_s && fifo_empty_s;
  assign cap_done_s = one_shot_q &&
                      (fifo_full_s || (wr_req_s && !rd_fire_s && (fill_level == LVL_LAST)));

  // Capture FSM next state; stop dominates arm
  always_comb begin
    state_d = state_q;
    if (!run_s || stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm)         state_d = ARMED;   else state_d = IDLE;
        ARMED:   if (frame_start) state_d = CAPTURE; else state_d = ARMED;
        CAPTURE: if (cap_done_s)  state_d = DONE;    else state_d = CAPTURE;
        DONE:    if (arm)         state_d = ARMED;   else state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Drop counter: cleared by arm, saturates at DROP_MAX
  always_comb begin
    dropped_d = dropped_q;
    if (arm_go_s) begin
      dropped_d = '0;
    end else if (wr_drop_s && (dropped_q != DROP_MAX)) begin
      dropped_d = dropped_q + 8'd1;
    end else begin
      dropped_d = dropped_q;
    end
  end

  // Control registers: state, latched one-shot mode, drop count, busy flag
  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      one_shot_q <= 1'b0;
      dropped_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      one_shot_q <= arm_go_s ? one_shot : one_shot_q;
      dropped_q  <= dropped_d;
      busy_q     <= (state_d == ARMED) || (state_d == CAPTURE);
    end
  end

`ifdef SLICE_LOG_TIMESTAMP_EN
  localparam logic [TS_WIDTH-1:0] TS_ONE = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  // Frame timestamp: zeroed on capture start, counts frame_start in CAPTURE
  always_comb begin
    ts_d = ts_q;
    if ((state_q == ARMED) && (state_d == CAPTURE)) begin
      ts_d = '0;
    end else if ((state_q == CAPTURE) && frame_start) begin
      ts_d = ts_q + TS_ONE;
    end else begin
      ts_d = ts_q;
    end
  end

  // Timestamp register; samples see the pre-increment value
  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
  assign ts_s = ts_q;
`else
  assign ts_s = '0;
`endif

  // Assemble the FIFO word from the value present as the delayed trigger emerges
  always_comb begin
    wr_word_s = '0;
    wr_word_s[OFF_VALUE +: DATA_WIDTH] = log_value_in;
    wr_word_s[OFF_TS_L +: TS_WIDTH]    = ts_s;
    wr_word_s[OFF_SLOT_L +: SLOT_WIDTH] = slot_dly_q[LOG_LATENCY-1];
    wr_word_s[OFF_OVF1_L]              = overflow_stage_1;
    wr_word_s[OFF_OVF2_L]              = overflow_stage_2;
  end

  slice_log_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock_200),
    .rst_ni     (reset_n),
    .flush_i    (flush_s),
    .wr_en_i    (wr_req_s),
    .wr_data_i  (wr_word_s),
    .rd_ready_i (rd_ready),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .level_o    (fill_level),
    .wr_drop_o  (wr_drop_s)
  );

  assign dropped = dropped_q;
  assign busy    = busy_q;

endmodule
